// File: rtl/dff_pkg.sv
// Shared definitions for the elastic DFF pipeline.
// Count-width helper and default reset payload.
package dff_pkg;

    localparam int DFF_RESET_VAL = 0;

    // Bits needed to hold 0..depth inclusive.
    function automatic int clog2w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: valid bit plus payload register.
// Payload only loads on a valid upstream word so bubbles never toggle it.
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             stage_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (stage_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Parametrised elastic register pipeline with valid/ready backpressure,
// bubble collapse, synchronous flush and an occupancy counter.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_RESET_VAL)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [clog2w(DEPTH)-1:0] count
);

    localparam int CW = clog2w(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] r;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_acc;
    logic             out_acc;

    // Ready ripples from the output back to the input in the same cycle.
    always_comb begin
        logic acc;
        r   = '0;
        acc = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc  = !v[k] | acc;
            r[k] = acc;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = v[k-1];
            assign up_data  = d[k-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk         (clk),
            .reset_n     (reset_n),
            .flush       (flush),
            .up_valid    (up_valid),
            .up_data     (up_data),
            .stage_ready (r[k]),
            .valid       (v[k]),
            .data        (d[k])
        );
    end

    assign in_ready  = r[0] & !flush;
    assign out_valid = v[DEPTH-1] & !flush;
    assign out_data  = d[DEPTH-1];
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (in_acc & !out_acc) begin
            count <= count + CW'(1);
        end else if (out_acc & !in_acc) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a DEPTH=4/WIDTH=8 and a DEPTH=1/WIDTH=1 instance,
// per-cycle vector table plus scoreboards tracking words and occupancy.
module tb_dff_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;

    logic       a_flush;
    logic       a_in_valid;
    logic       a_in_ready;
    logic [7:0] a_in_data;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [7:0] a_out_data;
    logic [2:0] a_count;

    logic       b_flush;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [0:0] b_in_data;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [0:0] b_out_data;
    logic [0:0] b_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q4 [$];
    logic [0:0] q1 [$];
    int         m4 = 0;
    int         m1 = 0;

    dff_pipe #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'hA5)
    ) u_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .count     (a_count)
    );

    dff_pipe #(
        .WIDTH     (1),
        .DEPTH     (1),
        .RESET_VAL (1'b0)
    ) u_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .count     (b_count)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: decide at negedge what the coming posedge will transfer.
    always @(negedge clk) begin
        logic ia;
        logic oa;
        if (!reset_n) begin
            q4.delete();
            m4 = 0;
        end else begin
            check("a_count_sb", 32'(a_count), 32'(m4));
            check("a_in_ready_sb", 32'(a_in_ready),
                  32'(!a_flush && !(m4 == 4 && !a_out_ready)));
            if (a_flush) begin
                check("a_flush_out_valid", 32'(a_out_valid), 32'(0));
                q4.delete();
                m4 = 0;
            end else begin
                ia = a_in_valid && a_in_ready;
                oa = a_out_valid && a_out_ready;
                if (oa) begin
                    if (q4.size() == 0)
                        check("a_pop_empty", 32'(1), 32'(0));
                    else
                        check("a_data_sb", 32'(a_out_data), 32'(q4.pop_front()));
                end
                if (ia) q4.push_back(a_in_data);
                if (ia && !oa) m4++;
                else if (oa && !ia) m4--;
            end
        end
    end

    always @(negedge clk) begin
        logic ib;
        logic ob;
        if (!reset_n) begin
            q1.delete();
            m1 = 0;
        end else begin
            check("b_count_sb", 32'(b_count), 32'(m1));
            check("b_in_ready_sb", 32'(b_in_ready),
                  32'(!b_flush && !(m1 == 1 && !b_out_ready)));
            if (b_flush) begin
                check("b_flush_out_valid", 32'(b_out_valid), 32'(0));
                q1.delete();
                m1 = 0;
            end else begin
                ib = b_in_valid && b_in_ready;
                ob = b_out_valid && b_out_ready;
                if (ob) begin
                    if (q1.size() == 0)
                        check("b_pop_empty", 32'(1), 32'(0));
                    else
                        check("b_data_sb", 32'(b_out_data), 32'(q1.pop_front()));
                end
                if (ib) q1.push_back(b_in_data);
                if (ib && !ob) m1++;
                else if (ob && !ib) m1--;
            end
        end
    end

    typedef struct {
        logic       iv;
        logic       orr;
        logic       fl;
        logic [7:0] din;
        int         cnt;
        logic       ir;
        logic       ov;
        logic [7:0] dout;
    } vec_t;

    function automatic vec_t mk(logic iv, logic orr, logic fl, logic [7:0] din,
                                int cnt, logic ir, logic ov, logic [7:0] dout);
        vec_t t;
        t.iv = iv; t.orr = orr; t.fl = fl; t.din = din;
        t.cnt = cnt; t.ir = ir; t.ov = ov; t.dout = dout;
        return t;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [36];
        logic [5:0] pat;

        // Stall fill, drain with 5 and 6 entering.
        tbl[0]  = mk(1, 0, 0, 8'h01, 0, 1, 0, 8'h0A);
        tbl[1]  = mk(1, 0, 0, 8'h02, 1, 1, 0, 8'h0A);
        tbl[2]  = mk(1, 0, 0, 8'h03, 2, 1, 0, 8'h0A);
        tbl[3]  = mk(1, 0, 0, 8'h04, 3, 1, 0, 8'h0A);
        tbl[4]  = mk(1, 0, 0, 8'h05, 4, 0, 1, 8'h01);
        tbl[5]  = mk(1, 0, 0, 8'h05, 4, 0, 1, 8'h01);
        tbl[6]  = mk(1, 1, 0, 8'h05, 4, 1, 1, 8'h01);
        tbl[7]  = mk(1, 1, 0, 8'h06, 4, 1, 1, 8'h02);
        tbl[8]  = mk(0, 1, 0, 8'h00, 4, 1, 1, 8'h03);
        tbl[9]  = mk(0, 1, 0, 8'h00, 3, 1, 1, 8'h04);
        tbl[10] = mk(0, 1, 0, 8'h00, 2, 1, 1, 8'h05);
        tbl[11] = mk(0, 1, 0, 8'h00, 1, 1, 1, 8'h06);
        tbl[12] = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h06);
        // Bubble collapse against a stalled consumer.
        tbl[13] = mk(1, 0, 0, 8'h11, 0, 1, 0, 8'h06);
        tbl[14] = mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h06);
        tbl[15] = mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h06);
        tbl[16] = mk(1, 0, 0, 8'h22, 1, 1, 0, 8'h06);
        tbl[17] = mk(0, 0, 0, 8'h00, 2, 1, 1, 8'h11);
        tbl[18] = mk(0, 0, 0, 8'h00, 2, 1, 1, 8'h11);
        tbl[19] = mk(0, 0, 0, 8'h00, 2, 1, 1, 8'h11);
        // Fill to full, then flush with both sides offering.
        tbl[20] = mk(1, 0, 0, 8'h33, 2, 1, 1, 8'h11);
        tbl[21] = mk(1, 0, 0, 8'h44, 3, 1, 1, 8'h11);
        tbl[22] = mk(1, 0, 0, 8'h55, 4, 0, 1, 8'h11);
        tbl[23] = mk(1, 1, 1, 8'h55, 4, 0, 0, 8'h11);
        tbl[24] = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h11);
        // Full with simultaneous in/out accept.
        tbl[25] = mk(1, 0, 0, 8'h61, 0, 1, 0, 8'h11);
        tbl[26] = mk(1, 0, 0, 8'h62, 1, 1, 0, 8'h11);
        tbl[27] = mk(1, 0, 0, 8'h63, 2, 1, 0, 8'h11);
        tbl[28] = mk(1, 0, 0, 8'h64, 3, 1, 0, 8'h11);
        tbl[29] = mk(1, 1, 0, 8'h65, 4, 1, 1, 8'h61);
        tbl[30] = mk(1, 1, 0, 8'h66, 4, 1, 1, 8'h62);
        tbl[31] = mk(0, 1, 0, 8'h00, 4, 1, 1, 8'h63);
        tbl[32] = mk(0, 1, 0, 8'h00, 3, 1, 1, 8'h64);
        tbl[33] = mk(0, 1, 0, 8'h00, 2, 1, 1, 8'h65);
        tbl[34] = mk(0, 1, 0, 8'h00, 1, 1, 1, 8'h66);
        tbl[35] = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h66);

        reset_n     = 1'b0;
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = 8'h00;
        a_out_ready = 1'b0;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 1'b0;
        b_out_ready = 1'b0;

        #12;
        check("rst_a_out_valid", 32'(a_out_valid), 32'(0));
        check("rst_a_out_data", 32'(a_out_data), 32'(8'hA5));
        check("rst_a_count", 32'(a_count), 32'(0));
        check("rst_a_in_ready", 32'(a_in_ready), 32'(1));
        check("rst_b_out_valid", 32'(b_out_valid), 32'(0));
        check("rst_b_out_data", 32'(b_out_data), 32'(0));
        check("rst_b_in_ready", 32'(b_in_ready), 32'(1));

        next_cycle();
        reset_n = 1'b1;

        // Streaming 0x01..0x0A with a free-running consumer.
        for (int i = 0; i < 14; i++) begin
            a_in_valid  = (i < 10);
            a_in_data   = 8'(i + 1);
            a_out_ready = 1'b1;
            @(negedge clk);
            check("stream_out_valid", 32'(a_out_valid), 32'(i >= 4));
            if (i >= 4)
                check("stream_out_data", 32'(a_out_data), 32'(i - 3));
            check("stream_count", 32'(a_count),
                  32'((i <= 10) ? ((i < 4) ? i : 4) : (14 - i)));
            next_cycle();
        end

        for (int i = 0; i < 36; i++) begin
            a_in_valid  = tbl[i].iv;
            a_out_ready = tbl[i].orr;
            a_flush     = tbl[i].fl;
            a_in_data   = tbl[i].din;
            @(negedge clk);
            check("vec_count", 32'(a_count), 32'(tbl[i].cnt));
            check("vec_in_ready", 32'(a_in_ready), 32'(tbl[i].ir));
            check("vec_out_valid", 32'(a_out_valid), 32'(tbl[i].ov));
            check("vec_out_data", 32'(a_out_data), 32'(tbl[i].dout));
            next_cycle();
        end
        a_in_valid = 1'b0;
        a_flush    = 1'b0;

        // DEPTH=1, WIDTH=1: continuous full with simultaneous accept.
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            b_in_valid  = 1'b1;
            b_out_ready = 1'b1;
            b_in_data   = pat[i];
            @(negedge clk);
            check("d1_out_valid", 32'(b_out_valid), 32'(i >= 1));
            if (i >= 1) begin
                check("d1_out_data", 32'(b_out_data), 32'(pat[i-1]));
                check("d1_count", 32'(b_count), 32'(1));
            end
            next_cycle();
        end
        b_in_data   = 1'b0;
        b_out_ready = 1'b0;
        @(negedge clk);
        check("d1_stall_in_ready", 32'(b_in_ready), 32'(0));
        check("d1_stall_out_data", 32'(b_out_data), 32'(pat[5]));
        next_cycle();
        b_flush     = 1'b1;
        b_out_ready = 1'b1;
        @(negedge clk);
        check("d1_flush_out_valid", 32'(b_out_valid), 32'(0));
        check("d1_flush_in_ready", 32'(b_in_ready), 32'(0));
        next_cycle();
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        @(negedge clk);
        check("d1_post_flush_count", 32'(b_count), 32'(0));
        check("d1_post_flush_out_valid", 32'(b_out_valid), 32'(0));
        check("d1_post_flush_hold", 32'(b_out_data), 32'(pat[5]));
        next_cycle();

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 6; i++) begin
            a_in_valid  = 1'b1;
            a_out_ready = 1'b1;
            a_in_data   = 8'(8'h80 + i);
            b_in_valid  = 1'b1;
            b_in_data   = 1'(i);
            next_cycle();
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_a_out_valid", 32'(a_out_valid), 32'(0));
        check("mid_rst_a_out_data", 32'(a_out_data), 32'(8'hA5));
        check("mid_rst_a_count", 32'(a_count), 32'(0));
        check("mid_rst_a_in_ready", 32'(a_in_ready), 32'(1));
        check("mid_rst_b_out_valid", 32'(b_out_valid), 32'(0));
        check("mid_rst_b_count", 32'(b_count), 32'(0));
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        next_cycle();
        reset_n = 1'b1;

        a_in_valid = 1'b1;
        a_in_data  = 8'h77;
        next_cycle();
        a_in_valid = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("post_rst_out_valid", 32'(a_out_valid), 32'(1));
        check("post_rst_out_data", 32'(a_out_data), 32'(8'h77));
        next_cycle();
        repeat (2) next_cycle();
        check("a_sb_empty", 32'(q4.size()), 32'(0));
        check("b_sb_empty", 32'(q1.size()), 32'(0));
        check("a_final_count", 32'(a_count), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
